bcd_conv_arbiter: RTL and testbench
===================================

Name: bcd_conv_arbiter

Overview:
- Shares one sequential bin2bcd converter between N_REQ requesters, e.g. the reaction-time display path and the best-time/statistics path.
- Each requester holds a level request with a 14-bit binary value. The arbiter grants round-robin, clamps the value to 4 BCD digits, and sequences the converter's start/done handshake.
- It returns the BCD result to the granted requester with a one-cycle ack.
- A watchdog covers a converter that never reports done.

Parameters:
- N_REQ, 2, number of requesters (legal range 2..4).
- TIMEOUT_CYCLES, 1_000, cycles allowed from conv_start to conv_done before abort.
- BCD_MAX, 9_999, largest value converted unclamped.

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  asynchronous, active-low reset.
- req  input  N_REQ  level request per requester; held high until its ack or err.
- bin_in  input  14*N_REQ  packed binary operands; requester i uses bits [14*i+13:14*i].
- ack  output  N_REQ  one-cycle pulse, result valid on bcd_out.
- err  output  N_REQ  one-cycle pulse, conversion timed out.
- ovf  output  1  valid with ack: operand was clamped to BCD_MAX.
- bcd_out  output  16  4-digit BCD result; held until the next ack.
- busy  output  1  high in any state other than IDLE.
- conv_start  output  1  one-cycle start pulse to the converter.
- conv_bin  output  14  operand to the converter, stable from start until done.
- conv_ready  input  1  converter is idle.
- conv_done  input  1  one-cycle done tick from the converter.
- conv_bcd  input  16  converter result, valid with conv_done.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ack=0, err=0, ovf=0, bcd_out=0, conv_start=0, conv_bin=0, busy=0; round-robin pointer=0; watchdog=0.
- IDLE:
  - If any req bit is set, select the first requester at or after the pointer (wrapping modulo N_REQ).
  - Latch its index and operand into registers. Operand > BCD_MAX latches BCD_MAX and sets the ovf_pending flag.
  - Go to ISSUE.
- ISSUE: wait for conv_ready=1, then pulse conv_start for exactly one cycle, clear the watchdog, go to WAIT.
- WAIT: watchdog increments every cycle.
  - On conv_done=1: capture conv_bcd and go to RESPOND.
  - On watchdog == TIMEOUT_CYCLES-1 with no done: go to ABORT.
  - conv_done on the same cycle as the watchdog limit counts as success.
- RESPOND (one cycle):
  - If req[idx] is still 1: pulse ack[idx], load bcd_out, drive ovf=ovf_pending.
  - Otherwise discard the result: no ack, bcd_out unchanged.
  - Pointer = idx+1 mod N_REQ. Go to IDLE.
- ABORT (one cycle): pulse err[idx] if req[idx]=1; bcd_out unchanged; advance pointer; go to IDLE.
- Latency with an ideal converter (ready=1, done L cycles after start): req to conv_start = 2 cycles; conv_done to ack = 1 cycle.
- conv_bin is driven from the latched operand, so a bin_in change after grant has no effect.
- Requester rules:
  - A requester must drop req in the cycle after its ack/err. If still high in IDLE, it re-competes under the rotated pointer (no starvation).
  - A req dropped before grant is never served.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,…,N_REQ-1,0.
- At most one of ack/err is high in any cycle; ack and err are one-hot.
- Stray conv_done in IDLE or ISSUE is ignored.
- Mid-operation reset: immediate return to IDLE, no ack issued; the converter is not notified.
- State encoding: 3 bits; the unused encoding returns to IDLE.

Decomposition:
- Shared package bcd_arb_pkg:
  - State localparams IDLE, ISSUE, WAIT, RESPOND, ABORT.
  - Width constants BIN_W=14, BCD_W=16.
  - Default BCD_MAX.
- One sub-module, rr_pick:
  - Combinational round-robin selector; inputs req and pointer, outputs index and found.
  - Reused later for a shared pseudo-random generator arbiter.

Test Plan:
- Single request: req=01, bin_in[0]=1234, converter done 5 cycles after start → ack=01 once, bcd_out=16'h1234, ovf=0, conv_start seen 2 cycles after req.
- Clamp: bin_in[1]=12_000, req=10 → conv_bin=9999, ack=10, bcd_out=16'h9999, ovf=1.
- Fairness: req=11 held continuously, each requester drops and re-raises req one cycle after its ack → grant order 0,1,0,1; no requester is served twice in a row.
- Timeout: conv_done never asserted, TIMEOUT_CYCLES=20 → err pulse 20 cycles after conv_start, no ack, bcd_out unchanged, busy=0 next cycle.
- Withdrawn request: req[0] dropped during WAIT → converter completes, no ack/err, pointer advances to 1.
- Reset mid-WAIT: reset=0 for 2 cycles → busy=0, ack=0, bcd_out=0; new req=01 afterwards served normally.

Source files
------------

// File: rtl/bcd_arb_pkg.sv
// Shared constants for the bin2bcd converter arbiter: state encoding and datapath widths.
package bcd_arb_pkg;

    localparam int unsigned BIN_W       = 14;
    localparam int unsigned BCD_W       = 16;
    localparam int unsigned BCD_MAX_DEF = 9_999;

    typedef logic [2:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t ISSUE   = 3'd1;
    localparam state_t WAIT    = 3'd2;
    localparam state_t RESPOND = 3'd3;
    localparam state_t ABORT   = 3'd4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter  int unsigned N_REQ = 2,
    localparam int unsigned PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    idx,
    output logic             found
);

    int unsigned cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = (32'(ptr) + k) % N_REQ;
            if (!found && req[PW'(cand)]) begin
                found = 1'b1;
                idx   = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one sequential bin2bcd converter between N_REQ requesters,
// with operand clamping, start/done sequencing and a done watchdog.
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1_000,
    parameter int unsigned BCD_MAX        = BCD_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [BIN_W*N_REQ-1:0] bin_in,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       err,
    output logic                   ovf,
    output logic [BCD_W-1:0]       bcd_out,
    output logic                   busy,
    output logic                   conv_start,
    output logic [BIN_W-1:0]       conv_bin,
    input  logic                   conv_ready,
    input  logic                   conv_done,
    input  logic [BCD_W-1:0]       conv_bcd
);

    localparam int unsigned PW   = $clog2(N_REQ);
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    state_t             state, state_next;
    logic [PW-1:0]      ptr, idx, pick_idx;
    logic               pick_found;
    logic [WD_W-1:0]    wd;
    logic               ovf_pending;
    logic [BIN_W-1:0]   op_sel, op_clamped;
    logic [N_REQ-1:0]   idx_onehot;
    logic               req_idx;

    logic [N_REQ-1:0]   ack_d, err_d;
    logic               ovf_d, start_d, busy_d;
    logic [BCD_W-1:0]   bcd_d;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign op_sel     = bin_in[32'(pick_idx)*BIN_W +: BIN_W];
    assign op_clamped = (32'(op_sel) > BCD_MAX) ? BIN_W'(BCD_MAX) : op_sel;
    assign idx_onehot = N_REQ'(1) << idx;
    assign req_idx    = req[idx];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; done on the watchdog limit cycle wins over abort
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_found) state_next = ISSUE;
            ISSUE:   if (conv_ready) state_next = WAIT;
            WAIT: begin
                if (conv_done)           state_next = RESPOND;
                else if (wd == WD_LIMIT) state_next = ABORT;
            end
            RESPOND: state_next = IDLE;
            ABORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode on the transition so each registered pulse lines up with its state
    always_comb begin
        ack_d   = '0;
        err_d   = '0;
        ovf_d   = 1'b0;
        bcd_d   = bcd_out;
        start_d = (state == ISSUE) && (state_next == WAIT);
        busy_d  = (state_next != IDLE);
        if (state == WAIT && state_next == RESPOND && req_idx) begin
            ack_d = idx_onehot;
            ovf_d = ovf_pending;
            bcd_d = conv_bcd;
        end
        if (state == WAIT && state_next == ABORT && req_idx) begin
            err_d = idx_onehot;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack        <= '0;
            err        <= '0;
            ovf        <= 1'b0;
            bcd_out    <= '0;
            conv_start <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ack        <= ack_d;
            err        <= err_d;
            ovf        <= ovf_d;
            bcd_out    <= bcd_d;
            conv_start <= start_d;
            busy       <= busy_d;
        end
    end

    // Grant latch, watchdog and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            conv_bin    <= '0;
            ovf_pending <= 1'b0;
            wd          <= '0;
            ptr         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        idx         <= pick_idx;
                        conv_bin    <= op_clamped;
                        ovf_pending <= (32'(op_sel) > BCD_MAX);
                    end
                end
                ISSUE:   if (conv_ready) wd <= '0;
                WAIT:    wd <= wd + WD_W'(1);
                RESPOND, ABORT: ptr <= (32'(idx) == N_REQ - 1) ? '0 : idx + PW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed self-checking bench for bcd_conv_arbiter with a behavioural converter model.
module tb_bcd_conv_arbiter;

    localparam int unsigned N = 2;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req;
    logic [27:0]   bin_in;
    logic [N-1:0]  ack, err;
    logic          ovf, busy, conv_start;
    logic [15:0]   bcd_out;
    logic [13:0]   conv_bin;
    logic          conv_ready, conv_done;
    logic [15:0]   conv_bcd;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int conv_lat = 5;   // 0 = converter never reports done

    int n_ack = 0, n_err = 0, n_start = 0, n_viol = 0;
    int start_cyc = -1;

    bcd_conv_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(20), .BCD_MAX(9_999)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .bin_in     (bin_in),
        .ack        (ack),
        .err        (err),
        .ovf        (ovf),
        .bcd_out    (bcd_out),
        .busy       (busy),
        .conv_start (conv_start),
        .conv_bin   (conv_bin),
        .conv_ready (conv_ready),
        .conv_done  (conv_done),
        .conv_bcd   (conv_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] to_bcd(input logic [13:0] b);
        int v;
        v = int'(b);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Converter model: done pulse conv_lat cycles after the start cycle
    initial begin
        int cnt;
        cnt = 0;
        conv_done = 1'b0;
        conv_bcd  = '0;
        forever begin
            @(negedge clk);
            conv_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    conv_done = 1'b1;
                    conv_bcd  = to_bcd(conv_bin);
                end
            end else if (conv_start && conv_lat != 0) begin
                cnt = conv_lat;
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (ack != 0) n_ack <= n_ack + 1;
        if (err != 0) n_err <= n_err + 1;
        if (conv_start) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
        end
        if ((ack != 0 && err != 0) || $countones(ack) > 1 || $countones(err) > 1)
            n_viol <= n_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_resp(input int bound, output logic [N-1:0] a, output logic [N-1:0] e,
                             output int at);
        a  = '0;
        e  = '0;
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ack != 0 || err != 0) begin
                a  = ack;
                e  = err;
                at = cyc;
                break;
            end
        end
        check("resp_seen", 32'(a | e) != 0, 1);
    endtask

    task automatic wait_start(input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            seen = conv_start;
        end
        check("start_seen", 32'(seen), 1);
    endtask

    task automatic wait_idle(input int bound);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < bound && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
        end
        check("idle_seen", 32'(idle), 1);
    endtask

    initial begin
        logic [N-1:0] a, e;
        int at, req_cyc, base_ack, base_err;
        logic [N-1:0] order [4];

        reset = 1'b0; req = '0; bin_in = '0; conv_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_bcd", 32'(bcd_out), 0);
        check("rst_start", 32'(conv_start), 0);
        check("rst_conv_bin", 32'(conv_bin), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single request, latency checks
        conv_lat = 5;
        bin_in[13:0] = 14'd1234;
        req = 2'b01;
        req_cyc = cyc;
        wait_resp(50, a, e, at);
        req = '0;
        check("t1_ack", 32'(a), 32'h1);
        check("t1_bcd", 32'(bcd_out), 32'h1234);
        check("t1_ovf", 32'(ovf), 0);
        check("t1_req2start", 32'(start_cyc - req_cyc), 2);
        check("t1_start2ack", 32'(at - start_cyc), 6);
        repeat (4) @(negedge clk);
        check("t1_ack_once", 32'(n_ack), 1);

        // Clamp
        bin_in[27:14] = 14'd12000;
        req = 2'b10;
        wait_resp(50, a, e, at);
        req = '0;
        check("t2_ack", 32'(a), 32'h2);
        check("t2_conv_bin", 32'(conv_bin), 9999);
        check("t2_bcd", 32'(bcd_out), 32'h9999);
        check("t2_ovf", 32'(ovf), 1);
        wait_idle(10);

        // Fairness with both requesters re-raising after each ack
        bin_in = {14'd7, 14'd42};
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_resp(50, a, e, at);
            order[i] = a;
            if (a == 2'b01) check("t3_bcd0", 32'(bcd_out), 32'h0042);
            else            check("t3_bcd1", 32'(bcd_out), 32'h0007);
            if (i == 3) begin
                req = '0;
            end else begin
                req = req & ~a;
                @(negedge clk);
                req = req | a;
            end
        end
        check("t3_g0", 32'(order[0]), 1);
        check("t3_g1", 32'(order[1]), 2);
        check("t3_g2", 32'(order[2]), 1);
        check("t3_g3", 32'(order[3]), 2);
        wait_idle(10);

        // Timeout: converter never reports done
        conv_lat = 0;
        bin_in[13:0] = 14'd555;
        base_ack = n_ack;
        req = 2'b01;
        wait_resp(80, a, e, at);
        req = '0;
        check("t4_err", 32'(e), 1);
        check("t4_noack", 32'(a), 0);
        check("t4_err_lat", 32'(at - start_cyc), 20);
        check("t4_bcd_kept", 32'(bcd_out), 32'h0007);
        @(negedge clk);
        check("t4_busy_low", 32'(busy), 0);
        check("t4_ack_cnt", 32'(n_ack - base_ack), 0);

        // Withdrawn request during WAIT
        conv_lat = 8;
        bin_in[13:0] = 14'd100;
        base_ack = n_ack; base_err = n_err;
        req = 2'b01;
        wait_start(20);
        repeat (2) @(negedge clk);
        req = '0;
        wait_idle(30);
        repeat (2) @(negedge clk);
        check("t5_no_ack", 32'(n_ack - base_ack), 0);
        check("t5_no_err", 32'(n_err - base_err), 0);
        check("t5_bcd_kept", 32'(bcd_out), 32'h0007);
        // Pointer must now favour requester 1
        conv_lat = 5;
        bin_in = {14'd31, 14'd30};
        req = 2'b11;
        wait_resp(50, a, e, at);
        req = 2'b01;
        check("t5_ptr_g1", 32'(a), 2);
        check("t5_bcd1", 32'(bcd_out), 32'h0031);
        wait_resp(50, a, e, at);
        req = '0;
        check("t5_ptr_g0", 32'(a), 1);
        check("t5_bcd0", 32'(bcd_out), 32'h0030);
        wait_idle(10);

        // Reset mid-WAIT, then a normal request
        conv_lat = 0;
        bin_in[13:0] = 14'd77;
        req = 2'b01;
        wait_start(20);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        req = '0;
        #1;
        check("t6_busy", 32'(busy), 0);
        check("t6_ack", 32'(ack), 0);
        check("t6_bcd", 32'(bcd_out), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        conv_lat = 3;
        @(negedge clk);
        bin_in[13:0] = 14'd2468;
        req = 2'b01;
        wait_resp(50, a, e, at);
        req = '0;
        check("t6_ack_after", 32'(a), 1);
        check("t6_bcd_after", 32'(bcd_out), 32'h2468);
        check("t6_ovf_after", 32'(ovf), 0);
        wait_idle(10);

        check("total_acks", 32'(n_ack), 9);
        check("total_errs", 32'(n_err), 1);
        check("onehot_resp", 32'(n_viol), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: sim time %0t exceeded bound", $time);
        $fatal(1, "bench time limit");
    end

endmodule
